// File: rtl/add_pkg.sv
// Shared add/subtract encoding and small arithmetic helpers for the pipelined adder.
package add_pkg;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } op_e;

  // Subtraction is a + ~b + !borrow_in, so the incoming carry inverts in SUB mode.
  function automatic logic eff_carry_in(input op_e op, input logic carry);
    case (op)
      ADD:     eff_carry_in = carry;
      SUB:     eff_carry_in = ~carry;
      default: eff_carry_in = carry;
    endcase
  endfunction

  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    signed_ovf = (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/pipe_add_slice.sv
// One SLICE_W-bit adder slice with its carry-out captured for the next pipeline stage.
module pipe_add_slice #(
  parameter int SLICE_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_en,
  input  logic [SLICE_W-1:0] i_a,
  input  logic [SLICE_W-1:0] i_b,
  input  logic               i_cin,
  output logic [SLICE_W-1:0] o_sum,
  output logic               o_cout
);

  logic [SLICE_W:0] w_sum;
  logic             r_cout;

  // Slice sum including the carry into the next slice.
  always_comb begin
    w_sum = {1'b0, i_a} + {1'b0, i_b} + {{SLICE_W{1'b0}}, i_cin};
  end

  // Carry register feeding the next stage; holds while the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cout <= 1'b0;
    end else if (i_en) begin
      r_cout <= w_sum[SLICE_W];
    end else begin
      r_cout <= r_cout;
    end
  end

  assign o_sum  = w_sum[SLICE_W-1:0];
  assign o_cout = r_cout;

endmodule

// File: rtl/pipe_add.sv
// Carry-pipelined adder/subtractor: one WIDTH/STAGES slice per stage, operands skewed
// forward, lower result slices deskewed so each transaction leaves in one piece.
module pipe_add
  import add_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int SW = WIDTH / STAGES;

  logic             w_stall;
  logic             w_en;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin_eff;
  logic             r_vld   [STAGES];
  logic [WIDTH-1:0] r_res   [STAGES];
  logic             w_carry [STAGES];
  logic             r_ovf;

  // A stall freezes every stage at once, so in_ready is simply its complement.
  assign w_stall  = r_vld[STAGES-1] && !out_ready;
  assign w_en     = !w_stall;
  assign in_ready = w_en;

  // Effective B operand: inverted when subtracting.
  always_comb begin
    case (op_e'(sub))
      SUB:     w_b_eff = ~b;
      ADD:     w_b_eff = b;
      default: w_b_eff = b;
    endcase
  end

  assign w_cin_eff = eff_carry_in(op_e'(sub), cin);

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int OPW = WIDTH - k * SW;

    logic [OPW-1:0]   w_a_op;
    logic [OPW-1:0]   w_b_op;
    logic             w_cin;
    logic             w_vld_in;
    logic [SW-1:0]    w_sum;
    logic [WIDTH-1:0] w_res_prev;
    logic [WIDTH-1:0] w_res_next;

    if (k == 0) begin : g_src
      assign w_a_op     = a;
      assign w_b_op     = w_b_eff;
      assign w_cin      = w_cin_eff;
      assign w_vld_in   = in_valid;
      assign w_res_prev = '0;
    end else begin : g_src
      logic [OPW-1:0] r_a;
      logic [OPW-1:0] r_b;

      // Operand bits not yet consumed travel with their transaction; no reset needed.
      always_ff @(posedge clk) begin
        if (w_en) begin
          r_a <= g_stg[k-1].w_a_op[OPW+SW-1:SW];
          r_b <= g_stg[k-1].w_b_op[OPW+SW-1:SW];
        end else begin
          r_a <= r_a;
          r_b <= r_b;
        end
      end

      assign w_a_op     = r_a;
      assign w_b_op     = r_b;
      assign w_cin      = w_carry[k-1];
      assign w_vld_in   = r_vld[k-1];
      assign w_res_prev = r_res[k-1];
    end

    pipe_add_slice #(
      .SLICE_W (SW)
    ) u_slice (
      .clk    (clk),
      .rst    (rst),
      .i_en   (w_en),
      .i_a    (w_a_op[SW-1:0]),
      .i_b    (w_b_op[SW-1:0]),
      .i_cin  (w_cin),
      .o_sum  (w_sum),
      .o_cout (w_carry[k])
    );

    // Merge this stage's slice into the result bits already finished upstream.
    always_comb begin
      w_res_next              = w_res_prev;
      w_res_next[k*SW +: SW]  = w_sum;
    end

    // Stage valid and partial-result register.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_vld[k] <= 1'b0;
        r_res[k] <= '0;
      end else if (w_en) begin
        r_vld[k] <= w_vld_in;
        r_res[k] <= w_res_next;
      end else begin
        r_vld[k] <= r_vld[k];
        r_res[k] <= r_res[k];
      end
    end

    if (k == STAGES - 1) begin : g_last
      // Signed overflow is decided by the top slice, alongside the final carry.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_ovf <= 1'b0;
        end else if (w_en) begin
          r_ovf <= signed_ovf(w_a_op[SW-1], w_b_op[SW-1], w_sum[SW-1]);
        end else begin
          r_ovf <= r_ovf;
        end
      end
    end
  end

  assign out_valid = r_vld[STAGES-1];
  assign result    = r_res[STAGES-1];
  assign cout      = w_carry[STAGES-1];
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_pipe_add.sv
// Scoreboard bench for pipe_add: 32/4 main instance plus 8/1 and 64/8 sweep instances.
`timescale 1ns/1ps
module tb_pipe_add;

  typedef struct packed {
    logic [63:0] res;
    logic        co;
    logic        ov;
  } exp_t;

  typedef struct {
    exp_t e;
    int   due;
  } sw_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic        rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [31:0] a, b, result;

  pipe_add #(.WIDTH(32), .STAGES(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .ovf(ovf)
  );

  logic        sw_rst;
  logic        s8_in_valid, s8_in_ready, s8_cin, s8_sub, s8_out_valid, s8_out_ready, s8_cout, s8_ovf;
  logic [7:0]  s8_a, s8_b, s8_result;
  logic        s64_in_valid, s64_in_ready, s64_cin, s64_sub, s64_out_valid, s64_out_ready, s64_cout, s64_ovf;
  logic [63:0] s64_a, s64_b, s64_result;

  pipe_add #(.WIDTH(8), .STAGES(1)) u_s8 (
    .clk(clk), .rst(sw_rst), .in_valid(s8_in_valid), .in_ready(s8_in_ready), .a(s8_a), .b(s8_b),
    .cin(s8_cin), .sub(s8_sub), .out_valid(s8_out_valid), .out_ready(s8_out_ready),
    .result(s8_result), .cout(s8_cout), .ovf(s8_ovf)
  );

  pipe_add #(.WIDTH(64), .STAGES(8)) u_s64 (
    .clk(clk), .rst(sw_rst), .in_valid(s64_in_valid), .in_ready(s64_in_ready), .a(s64_a), .b(s64_b),
    .cin(s64_cin), .sub(s64_sub), .out_valid(s64_out_valid), .out_ready(s64_out_ready),
    .result(s64_result), .cout(s64_cout), .ovf(s64_ovf)
  );

  exp_t q32[$];
  logic mv [4];

  // Reference: add as a wide sum, subtract as a true difference with a borrow bit.
  function automatic exp_t ref_calc(input int w, input logic [63:0] ta, input logic [63:0] tb,
                                    input logic tc, input logic ts);
    logic [64:0] s;
    logic [63:0] mask;
    exp_t        e;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    if (!ts) s = {1'b0, ta} + {1'b0, tb} + {64'd0, tc};
    else     s = {1'b0, ta} - {1'b0, tb} - {64'd0, tc};
    e.res = s[63:0] & mask;
    e.co  = ts ? ~s[w] : s[w];
    if (!ts) e.ov = (ta[w-1] == tb[w-1]) && (e.res[w-1] != ta[w-1]);
    else     e.ov = (ta[w-1] != tb[w-1]) && (e.res[w-1] != ta[w-1]);
    return e;
  endfunction

  // One cycle on the main instance: drive, sample, then advance valid model and scoreboard.
  task automatic step_m(input logic r, input logic v, input logic [31:0] ta, input logic [31:0] tb,
                        input logic tc, input logic ts, input logic ordy,
                        output logic o_ov, output logic o_ir, output exp_t o_got,
                        output logic e_ov, output logic e_ir, output exp_t e_val);
    logic acc;
    @(negedge clk);
    rst = r; in_valid = v; a = ta; b = tb; cin = tc; sub = ts; out_ready = ordy;
    #1;
    o_ov  = out_valid;
    o_ir  = in_ready;
    o_got = {32'd0, result, cout, ovf};
    e_ov  = mv[3];
    e_ir  = !(e_ov && !ordy);
    e_val = (q32.size() > 0) ? q32[0] : '0;
    acc   = v && e_ir && !r;
    if (r) begin
      q32.delete();
      for (int i = 0; i < 4; i++) mv[i] = 1'b0;
    end else begin
      if (e_ov && ordy && q32.size() > 0) void'(q32.pop_front());
      if (acc) q32.push_back(ref_calc(32, {32'd0, ta}, {32'd0, tb}, tc, ts));
      if (e_ir) begin
        for (int i = 3; i > 0; i--) mv[i] = mv[i-1];
        mv[0] = acc;
      end
    end
  endtask

  task automatic test_reset();
    logic o_ov, o_ir, e_ov, e_ir;
    exp_t o_got, e_val;
    step_m(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, o_ov, o_ir, o_got, e_ov, e_ir, e_val);
    step_m(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, o_ov, o_ir, o_got, e_ov, e_ir, e_val);
    step_m(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, o_ov, o_ir, o_got, e_ov, e_ir, e_val);
    n_checks++;
    if (o_ov !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", o_ov); end
    n_checks++;
    if (o_ir !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", o_ir); end
    n_checks++;
    if (o_got !== exp_t'(0)) begin n_fail++; $display("FAIL reset_outputs got %h exp 0", o_got); end
  endtask

  task automatic test_directed();
    logic [31:0] va[3], vb[3], vr[3];
    logic        vc[3], vs[3], vco[3], vov[3];
    logic        o_ov, o_ir, e_ov, e_ir;
    exp_t        o_got, e_val, got;
    int          lat;
    va[0] = 32'hFFFF_FFFF; vb[0] = 32'd1; vc[0] = 1'b0; vs[0] = 1'b0; vr[0] = 32'h0000_0000; vco[0] = 1'b1; vov[0] = 1'b0;
    va[1] = 32'h7FFF_FFFF; vb[1] = 32'd1; vc[1] = 1'b0; vs[1] = 1'b0; vr[1] = 32'h8000_0000; vco[1] = 1'b0; vov[1] = 1'b1;
    va[2] = 32'd5;         vb[2] = 32'd7; vc[2] = 1'b0; vs[2] = 1'b1; vr[2] = 32'hFFFF_FFFE; vco[2] = 1'b0; vov[2] = 1'b0;
    for (int t = 0; t < 3; t++) begin
      step_m(1'b0, 1'b1, va[t], vb[t], vc[t], vs[t], 1'b1, o_ov, o_ir, o_got, e_ov, e_ir, e_val);
      lat = -1;
      got = '0;
      for (int k = 1; k <= 10; k++) begin
        step_m(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, o_ov, o_ir, o_got, e_ov, e_ir, e_val);
        if (o_ov === 1'b1 && lat < 0) begin lat = k; got = o_got; end
      end
      n_checks++;
      if (lat !== 4) begin n_fail++; $display("FAIL dir%0d_latency got %0d exp 4", t, lat); end
      n_checks++;
      if (got.res[31:0] !== vr[t]) begin n_fail++; $display("FAIL dir%0d_result got %h exp %h", t, got.res[31:0], vr[t]); end
      n_checks++;
      if (got.co !== vco[t]) begin n_fail++; $display("FAIL dir%0d_cout got %b exp %b", t, got.co, vco[t]); end
      n_checks++;
      if (got.ov !== vov[t]) begin n_fail++; $display("FAIL dir%0d_ovf got %b exp %b", t, got.ov, vov[t]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ta[16], tb[16];
    logic        tc[16], ts[16];
    logic        o_ov, o_ir, e_ov, e_ir, ordy, v;
    exp_t        o_got, e_val;
    int          idx, delivered, j;
    for (int i = 0; i < 16; i++) begin
      ta[i] = $urandom; tb[i] = $urandom;
      tc[i] = 1'($urandom_range(0, 1)); ts[i] = 1'($urandom_range(0, 1));
    end
    ta[5] = 32'hFFFF_FFFF; tb[5] = 32'hFFFF_FFFF; tc[5] = 1'b1; ts[5] = 1'b0;
    ta[9] = 32'h8000_0000; tb[9] = 32'd1;         tc[9] = 1'b0; ts[9] = 1'b1;
    idx = 0;
    delivered = 0;
    for (int c = 0; c < 200 && (idx < 16 || q32.size() > 0); c++) begin
      ordy = (c % 4 == 0) || (c % 4 == 3);
      v    = (idx < 16);
      j    = (idx < 16) ? idx : 0;
      step_m(1'b0, v, ta[j], tb[j], tc[j], ts[j], ordy, o_ov, o_ir, o_got, e_ov, e_ir, e_val);
      n_checks++;
      if (o_ov !== e_ov) begin n_fail++; $display("FAIL b2b_out_valid c=%0d got %b exp %b", c, o_ov, e_ov); end
      n_checks++;
      if (o_ir !== e_ir) begin n_fail++; $display("FAIL b2b_in_ready c=%0d got %b exp %b", c, o_ir, e_ir); end
      if (e_ov) begin
        n_checks++;
        if (o_got !== e_val) begin n_fail++; $display("FAIL b2b_data c=%0d got %h exp %h", c, o_got, e_val); end
        if (ordy) delivered++;
      end
      if (v && e_ir) idx++;
    end
    n_checks++;
    if (delivered !== 16) begin n_fail++; $display("FAIL b2b_count got %0d exp 16", delivered); end
  endtask

  task automatic test_reset_flush();
    logic o_ov, o_ir, e_ov, e_ir;
    exp_t o_got, e_val;
    for (int i = 0; i < 3; i++)
      step_m(1'b0, 1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b1, o_ov, o_ir, o_got, e_ov, e_ir, e_val);
    step_m(1'b1, 1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b1, o_ov, o_ir, o_got, e_ov, e_ir, e_val);
    step_m(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, o_ov, o_ir, o_got, e_ov, e_ir, e_val);
    n_checks++;
    if (o_ov !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got %b exp 0", o_ov); end
    n_checks++;
    if (o_ir !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got %b exp 1", o_ir); end
    n_checks++;
    if (o_got !== exp_t'(0)) begin n_fail++; $display("FAIL flush_outputs got %h exp 0", o_got); end
    for (int k = 0; k < 8; k++) begin
      step_m(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, o_ov, o_ir, o_got, e_ov, e_ir, e_val);
      n_checks++;
      if (o_ov !== 1'b0) begin n_fail++; $display("FAIL flush_stale k=%0d got %b exp 0", k, o_ov); end
    end
  endtask

  task automatic test_sweep();
    sw_t  q8[$];
    sw_t  q64[$];
    sw_t  item;
    exp_t g;
    int   n8, n64, d8, d64;
    logic v8, v64, e8, e64;
    n8 = 0; n64 = 0; d8 = 0; d64 = 0;
    @(negedge clk);
    sw_rst = 1'b1; s8_in_valid = 1'b0; s64_in_valid = 1'b0;
    @(negedge clk);
    sw_rst = 1'b0;
    for (int cyc = 0; cyc < 4000 && (d8 < 1000 || d64 < 1000); cyc++) begin
      @(negedge clk);
      v8  = (n8 < 1000) && ($urandom_range(0, 7) != 0);
      v64 = (n64 < 1000) && ($urandom_range(0, 7) != 0);
      s8_in_valid  = v8;  s8_a  = 8'($urandom);        s8_b  = 8'($urandom);
      s8_cin  = 1'($urandom_range(0, 1)); s8_sub  = 1'($urandom_range(0, 1));
      s64_in_valid = v64; s64_a = {$urandom, $urandom}; s64_b = {$urandom, $urandom};
      s64_cin = 1'($urandom_range(0, 1)); s64_sub = 1'($urandom_range(0, 1));
      #1;
      n_checks++;
      if ((s8_in_ready & s64_in_ready) !== 1'b1) begin
        n_fail++; $display("FAIL sweep_in_ready cyc=%0d got %b%b exp 11", cyc, s8_in_ready, s64_in_ready);
      end
      e8 = (q8.size() > 0) && (q8[0].due == cyc);
      n_checks++;
      if (s8_out_valid !== e8) begin n_fail++; $display("FAIL s8_out_valid cyc=%0d got %b exp %b", cyc, s8_out_valid, e8); end
      if (e8) begin
        item = q8.pop_front();
        g = {56'd0, s8_result, s8_cout, s8_ovf};
        n_checks++;
        if (g !== item.e) begin n_fail++; $display("FAIL s8_data cyc=%0d got %h exp %h", cyc, g, item.e); end
        d8++;
      end
      e64 = (q64.size() > 0) && (q64[0].due == cyc);
      n_checks++;
      if (s64_out_valid !== e64) begin n_fail++; $display("FAIL s64_out_valid cyc=%0d got %b exp %b", cyc, s64_out_valid, e64); end
      if (e64) begin
        item = q64.pop_front();
        g = {s64_result, s64_cout, s64_ovf};
        n_checks++;
        if (g !== item.e) begin n_fail++; $display("FAIL s64_data cyc=%0d got %h exp %h", cyc, g, item.e); end
        d64++;
      end
      if (v8 && s8_in_ready) begin
        item.e = ref_calc(8, {56'd0, s8_a}, {56'd0, s8_b}, s8_cin, s8_sub);
        item.due = cyc + 1;
        q8.push_back(item);
        n8++;
      end
      if (v64 && s64_in_ready) begin
        item.e = ref_calc(64, s64_a, s64_b, s64_cin, s64_sub);
        item.due = cyc + 8;
        q64.push_back(item);
        n64++;
      end
    end
    n_checks++;
    if (d8 !== 1000) begin n_fail++; $display("FAIL s8_count got %0d exp 1000", d8); end
    n_checks++;
    if (d64 !== 1000) begin n_fail++; $display("FAIL s64_count got %0d exp 1000", d64); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = 32'd0; b = 32'd0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    sw_rst = 1'b1;
    s8_in_valid = 1'b0; s8_a = 8'd0; s8_b = 8'd0; s8_cin = 1'b0; s8_sub = 1'b0; s8_out_ready = 1'b1;
    s64_in_valid = 1'b0; s64_a = 64'd0; s64_b = 64'd0; s64_cin = 1'b0; s64_sub = 1'b0; s64_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) mv[i] = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_flush();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
